// File: rtl/mc_control_unit.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/write-back
// and decodes the datapath mux selects and write enables from the state register.
module mc_control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [3:0] funct,
  input  logic       mem_ready,
  output logic [3:0] state,
  output logic [3:0] next_state,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       Branch,
  output logic       LUI,
  output logic       SWB,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [2:0] BranchType,
  output logic       illegal_op,
  output logic       retire
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R    = 4'd6;
  localparam logic [3:0] S_ALU_WB    = 4'd7;
  localparam logic [3:0] S_EXEC_I    = 4'd8;
  localparam logic [3:0] S_BRANCH    = 4'd9;
  localparam logic [3:0] S_JUMP      = 4'd10;
  localparam logic [3:0] S_LUI_WB    = 4'd11;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;

  logic is_r, is_i, is_br, is_j, is_lw, is_sw, is_swb, is_lui, is_legal;

  always_comb begin
    is_r   = (opcode == 6'b000000);
    is_i   = (opcode[5:3] == 3'b001);
    is_br  = (opcode[5:2] == 4'b0001);
    is_j   = (opcode == 6'b000010);
    is_lw  = (opcode == 6'b100011);
    is_sw  = (opcode == 6'b101011);
    is_swb = (opcode == 6'b101000);
    is_lui = (opcode == 6'b010000);
    is_legal = is_r | is_i | is_br | is_j | is_lw | is_sw | is_swb | is_lui;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= next_state;
  end

  // mem_ready handshake: in FETCH, MEM_READ and MEM_WRITE the request is held
  // and the state does not advance until mem_ready=1 in that same cycle.
  always_comb begin
    next_state = S_FETCH;
    if (reset) begin
      case (state)
        S_FETCH:     next_state = mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          if (is_lw || is_sw || is_swb) next_state = S_MEM_ADDR;
          else if (is_r)                next_state = S_EXEC_R;
          else if (is_i)                next_state = S_EXEC_I;
          else if (is_br)               next_state = S_BRANCH;
          else if (is_j)                next_state = S_JUMP;
          else if (is_lui)              next_state = S_LUI_WB;
          else                          next_state = S_FETCH;
        end
        S_MEM_ADDR:  next_state = is_lw ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ:  next_state = mem_ready ? S_MEM_WB : S_MEM_READ;
        S_MEM_WB:    next_state = S_FETCH;
        S_MEM_WRITE: next_state = mem_ready ? S_FETCH : S_MEM_WRITE;
        S_EXEC_R:    next_state = S_ALU_WB;
        S_EXEC_I:    next_state = S_ALU_WB;
        S_ALU_WB:    next_state = S_FETCH;
        S_BRANCH:    next_state = S_FETCH;
        S_JUMP:      next_state = S_FETCH;
        S_LUI_WB:    next_state = S_FETCH;
        default:     next_state = S_FETCH;
      endcase
    end
  end

  // Everything is forced low while reset is asserted, even though state reads FETCH.
  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemtoReg   = 1'b0;
    Branch     = 1'b0;
    LUI        = 1'b0;
    SWB        = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'd0;
    ALUOp      = ALU_ADD;
    PCSource   = 2'd0;
    BranchType = 3'd0;
    illegal_op = 1'b0;
    retire     = 1'b0;
    if (reset) begin
      case (state)
        S_FETCH: begin
          MemRead = 1'b1;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
          ALUSrcB = 2'd1;
        end
        S_DECODE: begin
          ALUSrcB    = 2'd2;
          illegal_op = ~is_legal;
        end
        S_MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'd2;
        end
        S_MEM_READ: MemRead = 1'b1;
        S_MEM_WB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
          retire   = 1'b1;
        end
        S_MEM_WRITE: begin
          MemWrite = 1'b1;
          SWB      = is_swb;
          retire   = mem_ready;
        end
        S_EXEC_R: begin
          ALUSrcA = 1'b1;
          ALUOp   = funct;
        end
        S_EXEC_I: begin
          ALUSrcA = 1'b1;
          ALUSrcB = opcode[2] ? 2'd3 : 2'd2;
          ALUOp   = {1'b0, opcode[2:0]};
        end
        S_ALU_WB: begin
          RegWrite = 1'b1;
          retire   = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA    = 1'b1;
          ALUOp      = ALU_SUB;
          Branch     = 1'b1;
          PCSource   = 2'd1;
          BranchType = opcode[2:0];
          retire     = 1'b1;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'd2;
          retire   = 1'b1;
        end
        S_LUI_WB: begin
          LUI      = 1'b1;
          RegWrite = 1'b1;
          retire   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multicycle control FSM for the CPU datapath. It reads the opcode and function fields from the instruction register and sequences fetch, decode, execute, memory and write-back. On every cycle it drives the datapath's mux selects and write enables (PCWrite, IRWrite, RegWrite, MemRead/MemWrite, ALUOp, ALUSrcA/B, PCSource and so on). Memory phases stall on a ready handshake, and undefined opcodes are trapped.

## Interface
- No parameters; all encodings fixed below.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- opcode  in  6  IReg_out[31:26]
- funct  in  4  IReg_out[3:0]
- mem_ready  in  1  memory access completes this cycle
- state  out  4  current state
- next_state  out  4  combinational next state
- PCWrite, IRWrite, RegWrite, MemRead, MemWrite, MemtoReg, Branch, LUI, SWB  out  1 each  datapath controls
- ALUSrcA  out  1  0=PC, 1=regA
- ALUSrcB  out  2  0=regB, 1=const 4, 2=se_out, 3=ze_out
- ALUOp  out  4  ALU function; ADD=4'h0, SUB=4'h1
- PCSource  out  2  0=ALU_out, 1=ALUOut, 2=jump target
- BranchType  out  3  branch condition code (opcode[2:0])
- illegal_op  out  1  one-cycle pulse on undefined opcode
- retire  out  1  one-cycle pulse on the final cycle of each instruction

## Operation
- Opcode classes:
  - 000000: R-type.
  - 001xxx: I-type ALU.
  - 000100–000111: branch.
  - 000010: J.
  - 100011: LW.
  - 101011: SW.
  - 101000: SWB.
  - 010000: LUI.
  - Anything else is illegal.
- FETCH (0):
  - Drives MemRead=1, IRWrite=1, ALUSrcA=0, ALUSrcB=1, ALUOp=ADD, PCSource=0.
  - PCWrite=1 and IRWrite=1 only on the cycle where mem_ready=1.
  - Goes to DECODE on mem_ready; otherwise holds.
- DECODE (1):
  - Drives ALUSrcA=0, ALUSrcB=2, ALUOp=ADD, which forms the branch target into ALUOut.
  - Dispatches by opcode class:
    - LW/SW/SWB → MEM_ADDR (2).
    - R → EXEC_R (6).
    - I-type ALU → EXEC_I (8).
    - Branch → BRANCH (9).
    - J → JUMP (10).
    - LUI → LUI_WB (11).
    - Illegal → FETCH with illegal_op=1 and retire=0.
- MEM_ADDR (2): drives ALUSrcA=1, ALUSrcB=2, ALUOp=ADD. Goes to MEM_READ (3) for LW, otherwise MEM_WRITE (5).
- MEM_READ (3): MemRead=1; goes to MEM_WB (4) on mem_ready, otherwise holds.
- MEM_WB (4): RegWrite=1, MemtoReg=1, retire=1; goes to FETCH.
- MEM_WRITE (5):
  - MemWrite=1 held until mem_ready. SWB=1 throughout when the opcode is 101000.
  - Asserts retire on the mem_ready cycle, then goes to FETCH.
- EXEC_R (6): drives ALUSrcA=1, ALUSrcB=0, ALUOp=funct; goes to ALU_WB (7).
- EXEC_I (8):
  - Drives ALUSrcA=1, ALUOp={1'b0, opcode[2:0]}.
  - ALUSrcB=2 (sign-extend) when opcode[2]=0, else 3 (zero-extend).
  - Goes to ALU_WB (7).
- ALU_WB (7): RegWrite=1, MemtoReg=0, retire=1; goes to FETCH.
- BRANCH (9):
  - Drives ALUSrcA=1, ALUSrcB=0, ALUOp=SUB, Branch=1, PCSource=1, BranchType=opcode[2:0], PCWrite=0.
  - The datapath qualifies Branch to decide whether the PC is written.
  - retire=1; goes to FETCH.
- JUMP (10): PCWrite=1, PCSource=2, retire=1; goes to FETCH.
- LUI_WB (11): LUI=1, RegWrite=1, retire=1; goes to FETCH.
- Unused state codes 12–15 go to FETCH with all enables 0.
- Outputs are Moore-style decodes of the state register plus opcode/funct. The only Mealy terms are the mem_ready-qualified PCWrite, IRWrite and retire.
- Any control not listed for a state is 0.

## Timing
- While reset=0:
  - state=0 and next_state=0.
  - All 1-bit outputs are 0 (write enables are forced low even though the state is FETCH).
  - ALUOp=0, ALUSrcA=0, ALUSrcB=0, PCSource=0, BranchType=0.
- The first FETCH behaviour begins on the first rising edge after reset deasserts.
- The state register updates on the rising edge. Asserting reset mid-instruction returns to FETCH immediately; no write enable is asserted afterwards.
- Latency with mem_ready tied high:
  - R, I-type ALU, SW, SWB: 4 cycles.
  - LW: 5 cycles.
  - Branch, J, LUI: 3 cycles.
  - Illegal: 2 cycles.
- Each cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. All outputs are held stable during the stall.
- mem_ready is ignored in every other state.
- retire and illegal_op are each exactly one cycle wide per instruction and never both asserted.

## Test plan
- Hold reset low for 3 cycles, then release with mem_ready=1 → all enables 0 while in reset. Next cycle: state=0, MemRead=1, IRWrite=1, PCWrite=1.
- R-type (opcode=0, funct=4'h5) with mem_ready=1 → states 0,1,6,7,0. ALUOp=5 in state 6; RegWrite=1 and retire=1 only in state 7.
- LW with mem_ready low for 2 cycles in MEM_READ → states 0,1,2,3,3,3,4,0. MemRead held high through all three cycles in state 3.
- SWB (101000) → in state 5, MemWrite=1 and SWB=1. BNE-class opcode 000101 → in state 9, Branch=1, BranchType=3'b101, PCSource=1, PCWrite=0.
- Opcode 111111 → states 0,1,0 with illegal_op=1 for one cycle, and no RegWrite or MemWrite asserted.
- Assert reset during MEM_WRITE with mem_ready=0 → state=0 asynchronously and MemWrite drops to 0 within the same cycle.
